// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and default count width.
package countdown_timer_pkg;

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/countdown_timer_if.sv
// Control handshake between a controller (master) and the countdown timer (slave).
interface countdown_timer_if #(
    parameter int WIDTH = 6
);
    logic             en;
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output en, start, load_val, abort,
        input  count, busy, done
    );

    modport slave (
        input  en, start, load_val, abort,
        output count, busy, done
    );
endinterface

// File: rtl/countdown_timer_dec_nbit.sv
// WIDTH-bit combinational decrementer: adds all-ones with no carry-in.
module dec_nbit #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);
    assign y = a + {WIDTH{1'b1}};
endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/busy/done handshake and abort.
// Define COUNTDOWN_AUTORELOAD_EN for periodic reload instead of one-shot runs.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic               clk,
    input  logic               res,
    countdown_timer_if.slave   bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] count_dec;
`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tick_q, tick_d;
`endif

    dec_nbit #(.WIDTH(WIDTH)) u_dec (
        .a (count_q),
        .y (count_dec)
    );

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q  <= IDLE;
            count_q  <= '0;
`ifdef COUNTDOWN_AUTORELOAD_EN
            reload_q <= '0;
            tick_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
            reload_q <= reload_d;
            tick_q   <= tick_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
`ifdef COUNTDOWN_AUTORELOAD_EN
        reload_d = reload_q;
        tick_d   = 1'b0;
`endif
        case (state_q)
            RUN: begin
                // abort takes priority over the final decrement
                if (bus.abort) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (bus.en) begin
                    if (count_q == ONE) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                        count_d = reload_q;
                        tick_d  = 1'b1;
`else
                        state_d = DONE;
                        count_d = '0;
`endif
                    end else begin
                        count_d = count_dec;
                    end
                end
            end
            default: begin
                // IDLE and DONE accept start identically, so runs can chain without a gap
                state_d = IDLE;
                count_d = '0;
                if (bus.start && !bus.abort) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                    reload_d = bus.load_val;
`endif
                    if (bus.load_val != '0) begin
                        state_d = RUN;
                        count_d = bus.load_val;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
        endcase
    end

    assign bus.count = count_q;
    assign bus.busy  = (state_q == RUN);
`ifdef COUNTDOWN_AUTORELOAD_EN
    assign bus.done  = (state_q == DONE) || tick_q;
`else
    assign bus.done  = (state_q == DONE);
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Randomised and directed bench for countdown_timer against a cycle-level reference model.
module tb_countdown_timer;
    localparam int W = 6;
`ifdef COUNTDOWN_AUTORELOAD_EN
    localparam int BUSY_AT_DONE = 1;
`else
    localparam int BUSY_AT_DONE = 0;
`endif

    logic clk;
    logic res;
    countdown_timer_if #(.WIDTH(W)) bus ();

    countdown_timer #(.WIDTH(W)) dut (
        .clk (clk),
        .res (res),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_err = 0;
    string phase = "init";

    // Reference state: running flag, cycles remaining, pending done pulse, period.
    bit m_run;
    int m_rem;
    bit m_done;
    int m_reload;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0d expected %0d", phase, tag, obs, exp);
        end
    endtask

    task automatic ref_reset();
        m_run = 0; m_rem = 0; m_done = 0; m_reload = 0;
    endtask

    task automatic ref_tick(input bit e, input bit s, input int lv, input bit a);
        if (!m_run) begin
            m_done = 0;
            m_rem  = 0;
            if (s && !a) begin
                m_reload = lv;
                if (lv > 0) begin
                    m_run = 1;
                    m_rem = lv;
                end else begin
                    m_done = 1;
                end
            end
        end else begin
            m_done = 0;
            if (a) begin
                m_run = 0;
                m_rem = 0;
            end else if (e) begin
                if (m_rem == 1) begin
                    m_done = 1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                    m_rem = m_reload;
`else
                    m_run = 0;
                    m_rem = 0;
`endif
                end else begin
                    m_rem = m_rem - 1;
                end
            end
        end
    endtask

    task automatic step(input bit e, input bit s, input int lv, input bit a);
        logic [31:0] lv32;
        lv32 = lv;
        bus.en       = e;
        bus.start    = s;
        bus.load_val = lv32[W-1:0];
        bus.abort    = a;
        @(posedge clk);
        ref_tick(e, s, lv, a);
        #1;
        chk("count", bus.count, m_rem);
        chk("busy", bus.busy, m_run);
        chk("done", bus.done, m_done);
    endtask

    task automatic apply_reset();
        bus.en = 0; bus.start = 0; bus.abort = 0; bus.load_val = '0;
        #3;
        res = 1'b0;
        #1;
        ref_reset();
        chk("rst_count", bus.count, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        @(posedge clk);
        #1;
        chk("rst_hold_done", bus.done, 0);
        #1;
        res = 1'b1;
    endtask

    task automatic run_until_done(input int budget, output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        while (n < budget) begin
            step(1, 0, 0, 0);
            n++;
            if (bus.busy) busy_n++;
            if (bus.done) break;
        end
        if (!bus.done) begin
            n_chk++;
            n_err++;
            $display("FAIL %s/timeout: got no done within %0d cycles", phase, budget);
        end
    endtask

    initial begin
        int n, bn;
        res = 1'b0;
        bus.en = 0; bus.start = 0; bus.abort = 0; bus.load_val = '0;
        ref_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("por_count", bus.count, 0);
        chk("por_busy", bus.busy, 0);
        chk("por_done", bus.done, 0);
        #1;
        res = 1'b1;

        phase = "oneshot4";
        step(1, 1, 4, 0);
        chk("start_count", bus.count, 4);
        run_until_done(20, n, bn);
        chk("latency", n, 4);
        chk("busy_cycles", bn + 1, 4 + BUSY_AT_DONE);
        chk("end_count", bus.count, BUSY_AT_DONE ? 4 : 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
        chk("pulse_width", bus.done, 0);

        phase = "gate";
        step(1, 1, 3, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("hold", bus.count, 2);
        run_until_done(20, n, bn);
        chk("late_done", n, 2);
        step(0, 0, 0, 1);

        phase = "zero";
        step(1, 1, 0, 0);
        chk("zero_done", bus.done, 1);
        chk("zero_busy", bus.busy, 0);
        step(1, 0, 0, 0);
        chk("zero_after", bus.done, 0);

        phase = "abort_last";
        step(1, 1, 2, 0);
        step(1, 0, 0, 0);
        chk("at_one", bus.count, 1);
        step(1, 0, 0, 1);
        chk("ab_busy", bus.busy, 0);
        chk("ab_done", bus.done, 0);
        step(1, 0, 0, 0);
        chk("ab_nodone", bus.done, 0);

        phase = "abort_start";
        step(1, 1, 5, 1);
        chk("as_busy", bus.busy, 0);
        chk("as_count", bus.count, 0);

        phase = "b2b";
        step(1, 1, 0, 0);
        step(1, 1, 2, 0);
        chk("b2b_busy", bus.busy, 1);
        chk("b2b_count", bus.count, 2);
        step(1, 0, 0, 1);

        phase = "full";
        step(1, 1, 63, 0);
        run_until_done(100, n, bn);
        chk("full_latency", n, 63);
        step(1, 0, 0, 1);

        phase = "reset_mid";
        step(1, 1, 7, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("mid_count", bus.count, 5);
        apply_reset();
        step(1, 0, 0, 0);
        chk("post_rst_done", bus.done, 0);

`ifdef COUNTDOWN_AUTORELOAD_EN
        phase = "autoreload";
        step(1, 1, 3, 0);
        for (int i = 1; i <= 9; i++) begin
            step(1, 0, 0, 0);
            chk("ar_busy", bus.busy, 1);
            chk("ar_tick", bus.done, (i % 3) == 0);
        end
        step(1, 0, 0, 1);
        chk("ar_abort_busy", bus.busy, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0);
            chk("ar_stopped", bus.done, 0);
        end
`endif

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                apply_reset();
            end else begin
                bit e, s, a;
                int lv;
                e  = ($urandom_range(0, 3) != 0);
                s  = ($urandom_range(0, 3) == 0);
                a  = ($urandom_range(0, 19) == 0);
                lv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63))
                                                 : int'($urandom_range(0, 6));
                step(e, s, lv, a);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter with start/busy/done handshake; the counting-down counterpart to the datapath up-counters (counter32/counter64 family).
- Used by the processor control to time multi-cycle operations, e.g. multiply/divide iteration budgets and stall windows.
- Controller loads a cycle count and starts the timer; the timer counts it down and reports completion with a one-cycle done pulse.

Parameters:
- WIDTH, 6: width of the count; maximum load value is 2^WIDTH-1.

Ports:
- clk  in  1  system clock, rising-edge.
- res  in  1  reset; asynchronous, active-low.
- en  in  1  count enable; gates only the decrement.
- start  in  1  request; samples load_val when accepted.
- load_val  in  WIDTH  initial count.
- abort  in  1  cancels a run in progress.
- count  out  WIDTH  current count value, registered.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle completion pulse, registered.

Behaviour:
- Reset (res=0, asynchronous): state=IDLE, count=0, busy=0, done=0. This takes effect immediately, including mid-run. No done pulse is produced for an interrupted run.
- States: IDLE, RUN, DONE. Outputs are Moore: busy=(state==RUN), done=(state==DONE).
- IDLE:
  - start=1 and load_val!=0: count<=load_val, next state RUN.
  - start=1 and load_val==0: count<=0, next state DONE (zero-length run, done after 1 cycle, busy never asserted).
  - start is accepted regardless of en.
- RUN:
  - en=1 and count>1: count<=count-1.
  - en=1 and count==1: count<=0, next state DONE.
  - en=0: count and state hold.
  - start is ignored in RUN.
- DONE: lasts exactly one cycle, count=0. Next state is IDLE, unless start=1 in this cycle, which is handled exactly as in IDLE (back-to-back runs allowed, no dead cycle).
- abort:
  - In RUN: next state IDLE, count<=0, no done pulse.
  - abort beats a simultaneous count==1 decrement.
  - In IDLE or DONE, abort beats a simultaneous start: start is dropped.
- Latency, with en held high and load N>=1:
  - Start sampled at edge 0; busy high for cycles after edges 0..N-1 (N cycles).
  - count reaches 0 at edge N; done high for the single cycle after edge N.
- Arithmetic:
  - Decrement is unsigned, WIDTH bits.
  - count never wraps below 0; the count==1 -> DONE transition guarantees this.
  - Full-scale load 2^WIDTH-1 is legal.

Optional Feature:
- Macro: COUNTDOWN_AUTORELOAD_EN.
- Defined:
  - An internal reload register captures load_val on every accepted start.
  - In RUN, when count==1 and en=1: done pulses in the next cycle, count<=reload value, and the state stays in RUN (periodic tick every N enabled cycles). busy stays high throughout, so done may be high while busy=1 in this mode.
  - Only abort or reset leaves RUN.
  - Zero-length load still takes the one-shot path (IDLE -> DONE -> IDLE).
- Undefined: one-shot behaviour exactly as above, and no reload register is instantiated.

Decomposition:
- Shared package holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a default-width constant CNT_W=6.
- One sub-module, dec_nbit: parameterised WIDTH-bit combinational decrementer (count + all-ones, carry-in 0), mirroring how the up-counters pair a register with an adder.
- Control FSM and register stay in countdown_timer.

Test Plan:
- Reset: assert res=0 mid-RUN with count=5 -> count=0, busy=0, done=0 immediately. Release -> IDLE, no done pulse.
- One-shot: WIDTH=6, start with load_val=4, en=1 -> busy high 4 cycles, count 4,3,2,1,0, done high exactly 1 cycle, then IDLE.
- en gating: load 3, drop en for 2 cycles after first decrement -> count holds at 2, done arrives 2 cycles later than in the ungated run. load_val=0 -> done 1 cycle after start, busy never high.
- abort:
  - abort while count==1 and en=1 -> IDLE, count=0, no done.
  - abort and start together in IDLE -> stays IDLE.
- Back-to-back and full scale: start with load 2 during the DONE cycle of a prior run -> RUN next cycle with count=2. Load 63 -> done after exactly 63 enabled cycles.
- COUNTDOWN_AUTORELOAD_EN defined: load 3 -> done pulses every 3 cycles with busy continuously high. abort -> IDLE, pulses stop.
